// File: rtl/alu_rs_pkg.sv
// Shared types and default sizing for the integer ALU reservation station.
package alu_rs_pkg;

    localparam int RS_XLEN  = 32;
    localparam int RS_TAG_W = 6;
    localparam int RS_DEPTH = 8;

    typedef struct packed {
        logic                valid;
        logic [3:0]          alu_op;
        logic [RS_TAG_W-1:0] rob_tag;
        logic                src1_rdy;
        logic [RS_TAG_W-1:0] src1_tag;
        logic [RS_XLEN-1:0]  src1_val;
        logic                src2_rdy;
        logic [RS_TAG_W-1:0] src2_tag;
        logic [RS_XLEN-1:0]  src2_val;
    } rs_entry_t;

endpackage

// File: rtl/alu_rs_age_select.sv
// Oldest-candidate picker: one-hot grant of the candidate no other candidate is older than.
module alu_rs_age_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            cand,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,   // older[i][j]: entry i dispatched before entry j
    output logic [DEPTH-1:0]            grant
);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
        logic [DEPTH-1:0] beaten;
        for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
            assign beaten[gj] = (gi != gj) && cand[gj] && older[gj][gi];
        end
        assign grant[gi] = cand[gi] && !(|beaten);
    end

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station with CDB wakeup and oldest-first issue.
// ALU_RS_FAST_WAKEUP_EN: a source matching this cycle's CDB counts as ready for select.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int XLEN  = RS_XLEN,
    parameter int DEPTH = RS_DEPTH,
    parameter int TAG_W = RS_TAG_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     dispatch_valid,
    output logic                     dispatch_ready,
    input  logic [3:0]               dispatch_alu_op,
    input  logic [TAG_W-1:0]         dispatch_rob_tag,
    input  logic                     dispatch_src1_rdy,
    input  logic                     dispatch_src2_rdy,
    input  logic [TAG_W-1:0]         dispatch_src1_tag,
    input  logic [TAG_W-1:0]         dispatch_src2_tag,
    input  logic [XLEN-1:0]          dispatch_src1_val,
    input  logic [XLEN-1:0]          dispatch_src2_val,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [XLEN-1:0]          cdb_value,
    output logic                     issue_valid,
    output logic [3:0]               issue_alu_op,
    output logic [XLEN-1:0]          issue_operand1,
    output logic [XLEN-1:0]          issue_operand2,
    output logic [TAG_W-1:0]         issue_rob_tag,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]            ent_valid, wake1, wake2, cand, grant, alloc_oh;
    logic [DEPTH-1:0][DEPTH-1:0] older;
    logic [DEPTH-1:0][3:0]       ent_op;
    logic [DEPTH-1:0][TAG_W-1:0] ent_rob;
    logic [DEPTH-1:0][XLEN-1:0]  op1_fwd, op2_fwd;
    logic [IDX_W-1:0]            alloc_idx;
    logic                        dispatch_fire;
    rs_entry_t                   new_entry;
    logic [3:0]                  sel_op;
    logic [TAG_W-1:0]            sel_rob;
    logic [XLEN-1:0]             sel_op1, sel_op2;

    assign dispatch_ready = !(&ent_valid);
    assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;

    always_comb begin
        alloc_idx = '0;
        alloc_oh  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) alloc_idx = IDX_W'(i);
        end
        alloc_oh[alloc_idx] = dispatch_fire;
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + {{IDX_W{1'b0}}, ent_valid[i]};
        end
    end

    // A broadcast arriving in the dispatch cycle is captured directly into the new entry.
    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.alu_op   = dispatch_alu_op;
        new_entry.rob_tag  = dispatch_rob_tag;
        new_entry.src1_tag = dispatch_src1_tag;
        new_entry.src2_tag = dispatch_src2_tag;
        new_entry.src1_rdy = dispatch_src1_rdy || (cdb_valid && cdb_tag == dispatch_src1_tag);
        new_entry.src2_rdy = dispatch_src2_rdy || (cdb_valid && cdb_tag == dispatch_src2_tag);
        new_entry.src1_val = dispatch_src1_rdy ? dispatch_src1_val : cdb_value;
        new_entry.src2_val = dispatch_src2_rdy ? dispatch_src2_val : cdb_value;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        rs_entry_t        ent_reg;
        logic [DEPTH-1:0] older_reg;

        assign ent_valid[gi] = ent_reg.valid;
        assign ent_op[gi]    = ent_reg.alu_op;
        assign ent_rob[gi]   = ent_reg.rob_tag;
        assign older[gi]     = older_reg;
        assign wake1[gi] = cdb_valid && ent_reg.valid && !ent_reg.src1_rdy && (ent_reg.src1_tag == cdb_tag);
        assign wake2[gi] = cdb_valid && ent_reg.valid && !ent_reg.src2_rdy && (ent_reg.src2_tag == cdb_tag);

`ifdef ALU_RS_FAST_WAKEUP_EN
        assign cand[gi]    = ent_reg.valid && (ent_reg.src1_rdy || wake1[gi]) && (ent_reg.src2_rdy || wake2[gi]);
        assign op1_fwd[gi] = ent_reg.src1_rdy ? ent_reg.src1_val : cdb_value;
        assign op2_fwd[gi] = ent_reg.src2_rdy ? ent_reg.src2_val : cdb_value;
`else
        assign cand[gi]    = ent_reg.valid && ent_reg.src1_rdy && ent_reg.src2_rdy;
        assign op1_fwd[gi] = ent_reg.src1_val;
        assign op2_fwd[gi] = ent_reg.src2_val;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ent_reg <= '0;
            end else if (flush) begin
                ent_reg.valid <= 1'b0;
            end else if (alloc_oh[gi]) begin
                ent_reg <= new_entry;
            end else begin
                if (grant[gi]) ent_reg.valid <= 1'b0;
                if (wake1[gi]) begin
                    ent_reg.src1_rdy <= 1'b1;
                    ent_reg.src1_val <= cdb_value;
                end
                if (wake2[gi]) begin
                    ent_reg.src2_rdy <= 1'b1;
                    ent_reg.src2_val <= cdb_value;
                end
            end
        end

        // New arrival is older than nobody; every live entry becomes older than it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                older_reg <= '0;
            end else if (dispatch_fire) begin
                if (alloc_oh[gi]) older_reg <= '0;
                else              older_reg[alloc_idx] <= ent_reg.valid;
            end
        end
    end

    alu_rs_age_select #(.DEPTH(DEPTH)) u_age_select (
        .cand  (cand),
        .older (older),
        .grant (grant)
    );

    always_comb begin
        sel_op  = '0;
        sel_rob = '0;
        sel_op1 = '0;
        sel_op2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_op  = ent_op[i];
                sel_rob = ent_rob[i];
                sel_op1 = op1_fwd[i];
                sel_op2 = op2_fwd[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid    <= 1'b0;
            issue_alu_op   <= '0;
            issue_rob_tag  <= '0;
            issue_operand1 <= '0;
            issue_operand2 <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else begin
            issue_valid <= |grant;
            if (|grant) begin
                issue_alu_op   <= sel_op;
                issue_rob_tag  <= sel_rob;
                issue_operand1 <= sel_op1;
                issue_operand2 <= sel_op2;
            end
        end
    end

endmodule
